// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bus between the core and mem_responder
interface mem_responder_if;
  logic        req;
  logic        we;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;
  logic        err;

  modport master (output req, we, adr, wd, input rd, ready, err);
  modport slave  (input req, we, adr, wd, output rd, ready, err);
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - wait-state memory responder with bounds/alignment checking
// Optional tohost mailbox is built only when MEM_RESP_TOHOST_EN is defined.
module mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic           clk,
  input  logic           reset,
  mem_responder_if.slave bus,
  output logic [31:0]    tohost,
  output logic           tohost_valid
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] adr_q;
  logic [31:0] wd_q;
  logic        we_q;
  logic [31:0] rd_q;
  logic        ready_q;
  logic        err_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cur_adr;
  logic        cur_we;
  logic        cur_bad;
  logic        go_resp;

  // With zero wait states RESP is entered straight from IDLE, so the response
  // must be computed from the bus rather than the not-yet-latched copy.
  always_comb begin
    cur_adr = (state == IDLE) ? bus.adr : adr_q;
    cur_we  = (state == IDLE) ? bus.we  : we_q;
    cur_bad = (cur_adr[1:0] != 2'b00) || ({2'b00, cur_adr[31:2]} >= 32'(DEPTH_WORDS));
    go_resp = ((state == IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
              ((state == WAIT) && (cnt == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      adr_q   <= 32'd0;
      wd_q    <= 32'd0;
      we_q    <= 1'b0;
      rd_q    <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'd0;
      if (go_resp) begin
        ready_q <= 1'b1;
        err_q   <= cur_bad;
        if (!cur_we && !cur_bad) rd_q <= mem[cur_adr[AW+1:2]];
      end
      case (state)
        IDLE: begin
          if (bus.req) begin
            adr_q <= bus.adr;
            we_q  <= bus.we;
            wd_q  <= bus.wd;
            cnt   <= CNT_INIT;
            state <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Commit on the edge leaving RESP; a reset landing here aborts the write.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && we_q && !err_q) mem[adr_q[AW+1:2]] <= wd_q;
  end

  assign bus.rd    = rd_q;
  assign bus.ready = ready_q;
  assign bus.err   = err_q;

`ifdef MEM_RESP_TOHOST_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      tohost       <= 32'd0;
      tohost_valid <= 1'b0;
    end else if ((state == RESP) && we_q && !err_q && (adr_q == TOHOST_ADDR)) begin
      tohost       <= wd_q;
      tohost_valid <= 1'b1;
    end
  end
`else
  assign tohost       = 32'd0;
  assign tohost_valid = 1'b0;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - bench for mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances)
module tb_mem_responder;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();
  logic [31:0] tohost2, tohost0;
  logic        tv2, tv0;

  mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .TOHOST_ADDR(32'h0000_0100)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .tohost(tohost2), .tohost_valid(tv2));
  mem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .tohost(tohost0), .tohost_valid(tv0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt[12];
  logic [31:0] model [int];
  logic [31:0] exp_tohost;
  logic        exp_tv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d);
    if (s == 0) begin
      bus2.req = r; bus2.we = w; bus2.adr = a; bus2.wd = d;
    end else begin
      bus0.req = r; bus0.we = w; bus0.adr = a; bus0.wd = d;
    end
  endtask

  function automatic logic cur_ready(input int s);
    return (s == 0) ? bus2.ready : bus0.ready;
  endfunction

  // One request; returns response fields and the cycle count from accept to ready.
  task automatic txn(input int s, input logic w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rdo, output logic erro, output int lat);
    @(negedge clk);
    drive(s, 1'b1, w, a, d);
    lat = 0; rdo = 32'd0; erro = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (cur_ready(s)) begin
        lat  = k;
        rdo  = (s == 0) ? bus2.rd  : bus0.rd;
        erro = (s == 0) ? bus2.err : bus0.err;
        break;
      end
    end
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0);
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL timeout s=%0d adr=%h actual=no_ready required=ready", s, a);
    end else begin
      @(posedge clk); #1;
      chk("pulse_width", {31'd0, cur_ready(s)}, 32'd0);
    end
  endtask

  task automatic chk_tohost(input string name);
    chk({name, "_tohost"}, tohost2, exp_tohost);
    chk({name, "_tohost_valid"}, {31'd0, tv2}, {31'd0, exp_tv});
  endtask

  // Random traffic against an associative-array memory model.
  task automatic rand_phase(input int s, input int n);
    int unsigned depth  = (s == 0) ? 1024 : 16;
    int unsigned base   = (s == 0) ? 16 : 0;
    int          latexp = (s == 0) ? 3 : 1;
    logic [31:0] a, d, rdo, erd;
    logic        w, erro, eerr;
    int          lat, key;
    for (int i = 0; i < n; i++) begin
      int unsigned r = $urandom_range(0, 9);
      a = (base + $urandom_range(0, 15)) * 4;
      if (r == 0)      a = a | $urandom_range(1, 3);
      else if (r == 1) a = (depth + $urandom_range(0, 2000)) * 4;
      else if (r == 2) a = 32'hFFFF_FFFC;
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if (i < 16) begin
        a = (base + i) * 4;
        w = 1'b1;
      end
      eerr = (a % 4 != 0) || ((a / 4) >= depth);
      key  = s * (1 << 20) + int'(a / 4);
      txn(s, w, a, d, rdo, erro, lat);
      chk("rand_err", {31'd0, erro}, {31'd0, eerr});
      chk("rand_lat", lat, latexp);
      if (w || eerr) chk("rand_rd_zero", rdo, 32'd0);
      else if (model.exists(key)) begin
        erd = model[key];
        chk("rand_rd", rdo, erd);
      end
      if (w && !eerr) model[key] = d;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdo;
    logic        erro;
    int          lat;
    logic [13:0] pulses;

    checks = 0; errors = 0;
    exp_tohost = 32'd0; exp_tv = 1'b0;
    vt[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
    vt[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vt[2]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b1, 32'h0};
    vt[3]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[4]  = '{1'b1, 32'h0000_1000, 32'h0000_0001, 1'b1, 1'b1, 32'h0};
    vt[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[6]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0};
    vt[7]  = '{1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
    vt[8]  = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0};
    vt[10] = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
    vt[11] = '{1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, 1'b1, 32'h0};

    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready2", {31'd0, bus2.ready}, 32'd0);
    chk("reset_err2",   {31'd0, bus2.err},   32'd0);
    chk("reset_rd2",    bus2.rd,             32'd0);
    chk("reset_ready0", {31'd0, bus0.ready}, 32'd0);
    chk_tohost("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      txn(0, vt[i].we, vt[i].adr, vt[i].wd, rdo, erro, lat);
      chk($sformatf("vec%0d_err", i), {31'd0, erro}, {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d_lat", i), lat, 3);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rd", i), rdo, vt[i].exp_rd);
    end
    chk_tohost("after_vectors");

    // Reset during WAIT aborts the write to 0x20.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0055);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", {31'd0, bus2.ready}, 32'd0);
    chk("rst_mid_rd",    bus2.rd,             32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst_mid_no_ready", {31'd0, bus2.ready}, 32'd0);
    end
    txn(0, 1'b0, 32'h0000_0020, 32'd0, rdo, erro, lat);
    chk("rst_mid_readback", rdo, 32'h1111_2222);

    // Held req for 10 cycles: accepts every WAIT_CYCLES+2 cycles.
    pulses = '0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0);
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      pulses[k] = bus2.ready;
      if (bus2.ready) chk("held_rd", bus2.rd, 32'hDEAD_BEEF);
      if (k == 9) drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    chk("held_pulses", {18'd0, pulses}, 32'h0000_0444);

    // Mailbox: sticky once written.
`ifdef MEM_RESP_TOHOST_EN
    exp_tohost = 32'h0000_0001; exp_tv = 1'b1;
`endif
    txn(0, 1'b1, 32'h0000_0100, 32'h0000_0001, rdo, erro, lat);
    chk("tohost_wr_err", {31'd0, erro}, 32'd0);
    chk_tohost("tohost_wr");
    txn(0, 1'b1, 32'h0000_0044, 32'h0000_0077, rdo, erro, lat);
    model[17] = 32'h0000_0077;
    chk_tohost("tohost_other");
    txn(0, 1'b0, 32'h0000_0100, 32'd0, rdo, erro, lat);
    chk("tohost_ram_rd", rdo, 32'h0000_0001);

    // Zero wait states.
    txn(1, 1'b1, 32'h0000_0000, 32'h0000_00A1, rdo, erro, lat);
    chk("w0_wr_lat", lat, 1);
    txn(1, 1'b0, 32'h0000_0000, 32'd0, rdo, erro, lat);
    chk("w0_rd_lat", lat, 1);
    chk("w0_rd",     rdo, 32'h0000_00A1);
    txn(1, 1'b0, 32'h0000_0040, 32'd0, rdo, erro, lat);
    chk("w0_oor_err", {31'd0, erro}, 32'd1);
    chk("w0_oor_rd",  rdo, 32'd0);
    chk("w0_tohost", tohost0, 32'd0);
    chk("w0_tohost_valid", {31'd0, tv0}, 32'd0);

    rand_phase(0, 120);
    rand_phase(1, 120);
    chk_tohost("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
